// File: rtl/serial_subtractor_if.sv
// Start/operand/result bundle for the bit-serial subtractor.
// The requester side is master; the subtractor side is slave.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrowIn;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrowOut;
    logic             overflow;

    modport master (
        output start, a, b, borrowIn,
        input  busy, done, diff, borrowOut, overflow
    );

    modport slave (
        input  start, a, b, borrowIn,
        output busy, done, diff, borrowOut, overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: one full-subtractor cell, a registered borrow,
// WIDTH+1 cycles from accepted start to a one-cycle done pulse.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rstN,
    serial_subtractor_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PENULT_BIT = CNT_W'(WIDTH - 2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] result;
    logic             br;
    logic             msb_borrow_in;

    logic             ai;
    logic             bi;
    logic             d;
    logic             bo;
    logic [WIDTH-1:0] next_result;

    // NOTE: always_comb assigns every output on every pass, so no latch is inferred.
    always_comb begin
        ai          = a_sr[0];
        bi          = b_sr[0];
        d           = ai ^ bi ^ br;
        bo          = (~ai & bi) | (~(ai ^ bi) & br);
        next_result = {d, result[WIDTH-1:1]};
    end

    // NOTE: sequential state uses non-blocking assignments only; the operand
    // shift registers are ordinary flops and are cleared by reset with the rest.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            a_sr          <= '0;
            b_sr          <= '0;
            result        <= '0;
            br            <= 1'b0;
            msb_borrow_in <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.diff      <= '0;
            bus.borrowOut <= 1'b0;
            bus.overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_sr     <= bus.a;
                        b_sr     <= bus.b;
                        br       <= bus.borrowIn;
                        bit_cnt  <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    result <= next_result;
                    br     <= bo;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    if (bit_cnt == PENULT_BIT) begin
                        msb_borrow_in <= bo;
                    end
                    // Results are published only here, so the outputs never show a partial word.
                    if (bit_cnt == LAST_BIT) begin
                        bus.diff      <= next_result;
                        bus.borrowOut <= bo;
                        bus.overflow  <= msb_borrow_in ^ bo;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        state         <= DONE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor, LSB first: computes diff = a - b - borrowIn at one bit per clock through a single full-subtractor cell and a registered borrow.
- It is the subtract-direction counterpart to the team's full-adder datapath cells.
- Intended for area-constrained arithmetic paths. Operands are loaded on a start handshake; results are returned with a one-cycle done pulse.

Parameters:
WIDTH, 8, operand/result width in bits (min 2).

Ports:
clk  input  1  rising-edge clock.
rstN  input  1  asynchronous, active-low reset.
start  input  1  request; sampled on rising clk; accepted only when not busy.
a  input  WIDTH  minuend; latched when start is accepted.
b  input  WIDTH  subtrahend; latched when start is accepted.
borrowIn  input  1  initial borrow; latched when start is accepted.
busy  output  1  high while bits are being processed.
done  output  1  single-cycle pulse; results are valid.
diff  output  WIDTH  difference a - b - borrowIn, modulo 2^WIDTH.
borrowOut  output  1  borrow out of the MSB (1 = unsigned underflow).
overflow  output  1  two's-complement overflow: borrow into MSB XOR borrow out of MSB.

Behaviour:
- Reset: rstN low asynchronously clears everything.
  - Outputs: busy=0, done=0, diff=0, borrowOut=0, overflow=0.
  - Internals: state=IDLE, bit counter=0, borrow register=0, operand shift registers=0.
  - Reset takes effect mid-operation; the partial result is discarded.
  - Release is synchronous in effect: the first functional edge is the first rising clk with rstN high.
- States:
  - IDLE: start=1 at edge -> latch a, b and borrowIn into shift registers and the borrow reg; counter=0; go to RUN; busy=1 after the edge.
  - RUN, each edge:
    - Cell inputs: ai = a shift reg bit0, bi = b shift reg bit0, br = borrow reg.
    - d = ai ^ bi ^ br.
    - bo = (~ai & bi) | (~(ai ^ bi) & br).
    - d is shifted into the result reg MSB-side (result shifts right).
    - br <= bo; operand regs shift right; counter++.
    - On the edge processing bit WIDTH-2: capture bo as the MSB carry-in (borrow into MSB) for the overflow calculation.
    - On the edge processing bit WIDTH-1:
      - diff <= full result; borrowOut <= bo; overflow <= msbBorrowIn ^ bo.
      - busy <= 0; done <= 1; go to DONE.
  - DONE: lasts exactly one cycle; done=1, busy=0.
    - start=1 in this cycle is accepted like IDLE (back-to-back), and done returns to 0 the next cycle.
    - Otherwise go to IDLE with done=0.
- Latency: start accepted at edge E0; bits processed at edges E1..E(WIDTH); done=1 and results valid in the cycle after E(WIDTH). Total WIDTH+1 cycles from the start edge to done.
- Result outputs:
  - diff, borrowOut and overflow update only at the final RUN edge; they hold their value through IDLE and during the next RUN until that run's final edge.
  - They never show partial results.
- start while busy=1: ignored, with no effect on operands, counter or outputs. a, b and borrowIn may change freely after acceptance.
- Counter width: clog2(WIDTH); terminal count is WIDTH-1. No wrap beyond the terminal count.
- Boundaries:
  - a=b with borrowIn=0 -> diff=0, borrowOut=0.
  - a=0, b=0, borrowIn=1 -> diff=all ones, borrowOut=1, overflow=0.
  - Unsigned borrowOut and signed overflow are independent flags; both may be 1 at once (e.g. 0x7F-0x80 at WIDTH=8).
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
1. WIDTH=8, a=100, b=37, borrowIn=0, start pulse -> busy high for 8 cycles; done pulse 9 cycles after the start edge; diff=63 (0x3F), borrowOut=0, overflow=0.
2. a=0x00, b=0x01, borrowIn=0 -> diff=0xFF, borrowOut=1, overflow=0. Then a=0x80, b=0x01 -> diff=0x7F, borrowOut=0, overflow=1. Then a=0x7F, b=0x80 -> diff=0xFF, borrowOut=1, overflow=1.
3. a=0x05, b=0x05, borrowIn=1 -> diff=0xFF, borrowOut=1. Then a=0x05, b=0x05, borrowIn=0 -> diff=0x00, borrowOut=0.
4. Start a=0x10, b=0x01; pulse start with a=0xAA, b=0x55 at cycle 3 of RUN, and change a/b every cycle -> ignored; result is 0x0F, with done at the nominal cycle.
5. Assert start with new operands (0x20, 0x01) during the done cycle -> done drops the next cycle and busy rises; second result 0x1F arrives WIDTH+1 cycles later; diff holds 0x0F until then.
6. Pull rstN low asynchronously mid-RUN (cycle 4) -> all outputs 0 immediately. After release, with no start, outputs stay 0. A fresh start of 9-4 gives diff=5, borrowOut=0.
